// File: rtl/param_calculator.sv
// Multi-cycle add/sub/shift-add multiply/restoring divide calculator with one-hot state flags.
// Define CALC_REMAINDER_EN to build the division remainder register; otherwise Rem is tied to 0.
module param_calculator #(
  parameter int WIDTH = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [WIDTH-1:0]   In,
  input  logic               SCEN,
  input  logic               ButU,
  input  logic               ButD,
  input  logic               ButR,
  input  logic               ButL,
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] Result,
  output logic [WIDTH-1:0]   Rem,
  output logic               Flag,
  output logic               Done,
  output logic               QI,
  output logic               QGet_A,
  output logic               QGet_B,
  output logic               QGet_Op,
  output logic               QAdd,
  output logic               QSub,
  output logic               QMul,
  output logic               QDiv,
  output logic               QErr,
  output logic               QDone
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [9:0] {
    S_INIT  = 10'b00_0000_0001,
    S_GETA  = 10'b00_0000_0010,
    S_GETB  = 10'b00_0000_0100,
    S_GETOP = 10'b00_0000_1000,
    S_ADD   = 10'b00_0001_0000,
    S_SUB   = 10'b00_0010_0000,
    S_MUL   = 10'b00_0100_0000,
    S_DIV   = 10'b00_1000_0000,
    S_ERR   = 10'b01_0000_0000,
    S_DONE  = 10'b10_0000_0000
  } state_t;

  state_t               stateQ, stateD;
  logic [WIDTH-1:0]     aQ, aD, bQ, bD;
  logic [2*WIDTH-1:0]   resultQ, resultD;
  logic                 flagQ, flagD;
  logic [CW-1:0]        cntQ, cntD;
  // accQ is the partial product in MUL and the partial remainder in DIV
  logic [2*WIDTH-1:0]   accQ, accD, mcandQ, mcandD;
  logic [WIDTH-1:0]     workQ, workD;
  logic                 clearOut;
`ifdef CALC_REMAINDER_EN
  logic [WIDTH-1:0]     remQ, remD;
`endif

  logic [WIDTH:0]       sumFull;
  logic [WIDTH-1:0]     diff;
  logic [2*WIDTH-1:0]   prodNext;
  logic [WIDTH:0]       remShift, remTrial, remNext;
  logic                 divFits;
  logic [WIDTH-1:0]     quoNext;
  logic                 lastStep;

  assign sumFull  = {1'b0, aQ} + {1'b0, bQ};
  assign diff     = aQ - bQ;
  assign prodNext = accQ + (workQ[0] ? mcandQ : '0);
  assign remShift = {accQ[WIDTH-1:0], workQ[WIDTH-1]};
  assign remTrial = remShift - {1'b0, bQ};
  // A negative trial difference always lands with its top bit set, since remShift < 2*B
  assign divFits  = ~remTrial[WIDTH];
  assign remNext  = divFits ? remTrial : remShift;
  assign quoNext  = {workQ[WIDTH-2:0], divFits};
  assign lastStep = (cntQ == LAST_STEP);

  always_comb begin
    stateD   = stateQ;
    aD       = aQ;
    bD       = bQ;
    resultD  = resultQ;
    flagD    = flagQ;
    cntD     = cntQ;
    accD     = accQ;
    mcandD   = mcandQ;
    workD    = workQ;
    clearOut = 1'b0;
`ifdef CALC_REMAINDER_EN
    remD     = remQ;
`endif
    unique case (stateQ)
      S_INIT: begin
        clearOut = 1'b1;
        if (SCEN) stateD = S_GETA;
      end
      S_GETA: begin
        aD = In;
        if (SCEN) stateD = S_GETB;
      end
      S_GETB: begin
        bD = In;
        if (SCEN) stateD = S_GETOP;
      end
      S_GETOP: begin
        accD   = '0;
        mcandD = {{WIDTH{1'b0}}, bQ};
        workD  = aQ;
        cntD   = '0;
        if (ButU) begin
          stateD = S_MUL;
        end else if (ButD) begin
          if (bQ == '0) begin
            stateD  = S_ERR;
            flagD   = 1'b1;
            resultD = '0;
          end else begin
            stateD = S_DIV;
          end
        end else if (ButR) begin
          stateD = S_ADD;
        end else if (ButL) begin
          stateD = S_SUB;
        end
      end
      S_ADD: begin
        resultD = {{(WIDTH-1){1'b0}}, sumFull};
        flagD   = sumFull[WIDTH];
        stateD  = S_DONE;
      end
      S_SUB: begin
        resultD = {{WIDTH{1'b0}}, diff};
        flagD   = (aQ < bQ);
        stateD  = S_DONE;
      end
      S_MUL: begin
        accD   = prodNext;
        mcandD = mcandQ << 1;
        workD  = workQ >> 1;
        cntD   = cntQ + CW'(1);
        if (lastStep) begin
          resultD = prodNext;
          flagD   = |prodNext[2*WIDTH-1:WIDTH];
          stateD  = S_DONE;
        end
      end
      S_DIV: begin
        accD  = {{(WIDTH-1){1'b0}}, remNext};
        workD = quoNext;
        cntD  = cntQ + CW'(1);
        if (lastStep) begin
          resultD = {{WIDTH{1'b0}}, quoNext};
`ifdef CALC_REMAINDER_EN
          remD    = remNext[WIDTH-1:0];
          flagD   = |remNext[WIDTH-1:0];
`else
          flagD   = 1'b0;
`endif
          stateD  = S_DONE;
        end
      end
      S_ERR, S_DONE: begin
        if (SCEN) begin
          clearOut = 1'b1;
          stateD   = S_INIT;
        end
      end
      default: stateD = S_INIT;
    endcase
    if (clearOut) begin
      aD      = '0;
      bD      = '0;
      resultD = '0;
      flagD   = 1'b0;
`ifdef CALC_REMAINDER_EN
      remD    = '0;
`endif
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stateQ  <= S_INIT;
      aQ      <= '0;
      bQ      <= '0;
      resultQ <= '0;
      flagQ   <= 1'b0;
      cntQ    <= '0;
      accQ    <= '0;
      mcandQ  <= '0;
      workQ   <= '0;
    end else begin
      stateQ  <= stateD;
      aQ      <= aD;
      bQ      <= bD;
      resultQ <= resultD;
      flagQ   <= flagD;
      cntQ    <= cntD;
      accQ    <= accD;
      mcandQ  <= mcandD;
      workQ   <= workD;
    end
  end

`ifdef CALC_REMAINDER_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) remQ <= '0;
    else       remQ <= remD;
  end
  assign Rem = remQ;
`else
  assign Rem = '0;
`endif

  assign A       = aQ;
  assign B       = bQ;
  assign Result  = resultQ;
  assign Flag    = flagQ;
  assign Done    = stateQ[9] | stateQ[8];
  assign QI      = stateQ[0];
  assign QGet_A  = stateQ[1];
  assign QGet_B  = stateQ[2];
  assign QGet_Op = stateQ[3];
  assign QAdd    = stateQ[4];
  assign QSub    = stateQ[5];
  assign QMul    = stateQ[6];
  assign QDiv    = stateQ[7];
  assign QErr    = stateQ[8];
  assign QDone   = stateQ[9];

endmodule
